// File: rtl/nibble_seq_add.sv
// Multi-nibble adder/subtractor that reuses one external 4-bit adder.
// It processes one nibble per clock, starting with the least significant nibble.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The producer holds its payload stable while valid=1 and ready=0.
module nibble_seq_add #(
  parameter int NIBBLES = 4,
  parameter int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         cin,
  input  logic         sub,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry;
  logic          last_nibble;

  assign last_nibble = (idx == IW'(NIBBLES - 1));
  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);

  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[4*idx +: 4];
      add_b   = b_reg[4*idx +: 4];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is A + ~B + 1, so the inverted operand and a forced carry are stored.
            a_reg <= op_a;
            b_reg <= sub ? ~op_b : op_b;
            carry <= sub ? 1'b1 : cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          result[4*idx +: 4] <= add_sum;
          carry              <= add_cout;
          if (last_nibble) begin
            idx   <= '0;
            cout  <= add_cout;
            ovf   <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]);
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_seq_add.sv
// Bench for nibble_seq_add: a behavioural 4-bit adder is attached to the add_* ports.
// Results are compared against an integer-arithmetic reference model.
module tb_nibble_seq_add;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] cin_seq;

  nibble_seq_add #(.NIBBLES(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .cin(cin), .sub(sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // The external 4-bit adder.
  always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: W-bit wrap-around arithmetic plus signed-range overflow detection.
  task automatic model(input logic [W-1:0] a, b, input logic ci, s,
                       output logic [W-1:0] er, output logic ec, eo);
    longint ua, ub, tot, sa, sb, sr;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      tot = ua - ub;
      ec  = (ua >= ub);
      sr  = sa - sb;
    end else begin
      tot = ua + ub + longint'(ci);
      ec  = (tot >= (longint'(1) << W));
      sr  = sa + sb + longint'(ci);
    end
    er = tot[W-1:0];
    eo = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
  endtask

  // Called at the negedge right after the accepting edge.
  // Walks the nibble phases, then checks the latency and the result.
  task automatic collect(input logic [W-1:0] a, b, input logic ci, s);
    logic [W-1:0] er, bb;
    logic ec, eo;
    int lat;
    bit seen;
    model(a, b, ci, s, er, ec, eo);
    bb = s ? ~b : b;
    lat = 0;
    seen = 0;
    cin_seq = '0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (out_valid) begin
        seen = 1;
      end else begin
        if (lat < N) begin
          check("add_a", add_a, a[4*lat +: 4]);
          check("add_b", add_b, bb[4*lat +: 4]);
          check("in_ready_busy", in_ready, 0);
          cin_seq[lat] = add_cin;
        end
        @(negedge clk);
        lat++;
      end
    end
    check("latency", lat, N);
    check("result", result, er);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    check("adder_idle_done", {add_a, add_b, add_cin}, 0);
  endtask

  // Holds the result for 'hold' cycles, then retires it.
  // When keep_valid is set, a competing request stays asserted throughout.
  task automatic run_op(input logic [W-1:0] a, b, input logic ci, s, input int hold,
                        input bit keep_valid);
    logic [W-1:0] er;
    logic ec, eo;
    model(a, b, ci, s, er, ec, eo);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1; op_a = a; op_b = b; cin = ci; sub = s;
    @(negedge clk);
    in_valid = keep_valid;
    op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    if (keep_valid) begin
      op_a = 16'h0003; op_b = 16'h0004; cin = 0; sub = 0;
    end
    collect(a, b, ci, s);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", {cout, ovf, result}, {ec, eo, er});
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("retire_valid", out_valid, 0);
    check("retire_in_ready", in_ready, 1);
    check("retained", {cout, ovf, result}, {ec, eo, er});
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {result, cout, ovf}, 0);
    check("rst_adder", {add_a, add_b, add_cin}, 0);

    run_op(16'h1234, 16'h0FCD, 1, 0, 0, 0);
    run_op(16'hFFFF, 16'h0001, 0, 0, 1, 0);
    check("carry_chain_cin", cin_seq, 4'b1110);
    run_op(16'h8000, 16'h0001, 0, 1, 0, 0);
    run_op(16'h8000, 16'h0001, 1, 1, 0, 0);

    // Back-pressure with a competing request that must wait until after retirement.
    run_op(16'h7FFF, 16'h0001, 0, 0, 5, 1);
    @(negedge clk);
    check("accept_after_retire", in_ready, 0);
    in_valid = 0;
    collect(16'h0003, 16'h0004, 0, 0);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;

    // Reset after two RUN edges abandons the operation.
    in_valid = 1; op_a = 16'h5555; op_b = 16'h3333; cin = 0; sub = 0;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrun_in_ready", in_ready, 1);
    check("midrun_out_valid", out_valid, 0);
    check("midrun_result", result, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midrun_no_pulse", out_valid, 0);
    end

    for (int t = 0; t < 1000; t++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
